sub_64_bit_seq: RTL

Multi-cycle 64-bit two's-complement subtractor, the counterpart of the ALU's combinational 64-bit adder.
- Computes D = a - b one SLICE-bit slice per clock, LSB slice first, with a registered borrow between slices.
- Reports borrow, signed overflow and zero flags.
- Sits in the ALU datapath beside the adder. Uses a start/busy/done handshake so the ALU sequencer can issue back-to-back operations.

---
 rtl/alu_pkg.sv | 16 +
 rtl/sub_slice.sv | 17 +
 rtl/sub_64_bit_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants and types for the sequential subtractor.
package alu_pkg;

    localparam int unsigned WIDTH_DEF   = 64;
    localparam int unsigned SLICE_DEF   = 16;
    localparam int unsigned NSLICES_DEF = WIDTH_DEF / SLICE_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/sub_slice.sv
// Combinational SLICE-bit subtractor with borrow in/out.
module sub_slice #(
    parameter int unsigned SLICE = 16
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             bin,
    output logic [SLICE-1:0] d,
    output logic             bout
);

    // The extra top bit of the widened difference is the borrow-out.
    always_comb begin
        {bout, d} = {1'b0, x} - {1'b0, y} - (SLICE+1)'(bin);
    end

endmodule

// File: rtl/sub_64_bit_seq.sv
// Multi-cycle subtractor: D = a - b, one slice per clock, LSB slice first.
module sub_64_bit_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             B,
    output logic             V,
    output logic             Z
);

    localparam int unsigned NSLICES = WIDTH / SLICE;
    localparam int unsigned IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    state_t state_q, state_d;

    logic [NSLICES-1:0][SLICE-1:0] a_r, b_r, partial_q, d_new;
    logic [IDX_W-1:0]              idx;
    logic                          borrow_r;
    logic                          accept;
    logic                          last;
    logic [SLICE-1:0]              slice_d;
    logic                          slice_bout;

    sub_slice #(.SLICE(SLICE)) u_slice (
        .x    (a_r[idx]),
        .y    (b_r[idx]),
        .bin  (borrow_r),
        .d    (slice_d),
        .bout (slice_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state; a start is honoured whenever no slices are in flight.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                accept = start;
                if (start) state_d = RUN;
            end
            RUN: begin
                last = (idx == LAST_IDX);
                if (last) state_d = DONE;
            end
            DONE: begin
                accept  = start;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Full result as it will look once the current slice is written.
    always_comb begin
        d_new      = partial_q;
        d_new[idx] = slice_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            D         <= '0;
            B         <= 1'b0;
            V         <= 1'b0;
            Z         <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            partial_q <= '0;
            idx       <= '0;
            borrow_r  <= 1'b0;
        end else begin
            busy <= (state_d == RUN);
            done <= (state_d == DONE);
            if (accept) begin
                a_r      <= a;
                b_r      <= b;
                idx      <= '0;
                borrow_r <= 1'b0;
            end else if (state_q == RUN) begin
                partial_q[idx] <= slice_d;
                borrow_r       <= slice_bout;
                idx            <= last ? '0 : idx + IDX_W'(1);
                if (last) begin
                    D <= d_new;
                    B <= slice_bout;
                    V <= (a_r[NSLICES-1][SLICE-1] != b_r[NSLICES-1][SLICE-1]) &&
                         (d_new[NSLICES-1][SLICE-1] != a_r[NSLICES-1][SLICE-1]);
                    Z <= (d_new == '0);
                end
            end
        end
    end

endmodule
